// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Brief    : Hardwired fetch/decode/execute sequencer for ArithmeticLogicUnitSystem.
//            Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes halt and raise Illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
  parameter int TW  = 3,
  parameter int OPW = 6
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [15:0]   IR_Data,
  input  logic [3:0]    Flags,
  output logic [2:0]    RF_OutASel,
  output logic [2:0]    RF_OutBSel,
  output logic [2:0]    RF_FunSel,
  output logic [3:0]    RF_RegSel,
  output logic [3:0]    RF_ScrSel,
  output logic [4:0]    ALU_FunSel,
  output logic          ALU_WF,
  output logic [1:0]    MuxASel,
  output logic [1:0]    MuxBSel,
  output logic [1:0]    MuxCSel,
  output logic          MuxDSel,
  output logic [1:0]    ARF_OutCSel,
  output logic [1:0]    ARF_OutDSel,
  output logic [1:0]    ARF_FunSel,
  output logic [2:0]    ARF_RegSel,
  output logic          IR_LH,
  output logic          IR_Write,
  output logic          Mem_WR,
  output logic          Mem_CS,
  output logic          DR_E,
  output logic [1:0]    DR_FunSel,
  output logic [TW-1:0] T,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic          Illegal,
`endif
  output logic          Halted
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [OPW-1:0] OP_BRA  = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'h01);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_MOVL = OPW'(6'h03);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h05);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'h06);
  localparam logic [OPW-1:0] OP_ORR  = OPW'(6'h07);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_LDB  = OPW'(6'h09);
  localparam logic [OPW-1:0] OP_STB  = OPW'(6'h0A);
  localparam logic [OPW-1:0] OP_HLT  = OPW'(6'h3F);

  localparam logic [1:0] ARF_SEL_AR = 2'b01;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          illegal_q, illegal_d;

  logic [OPW-1:0] op;
  logic [1:0]     rsel, dst, sr1, sr2;
  logic           s_bit, z_flag;
  logic           unused_bits;

  assign op     = IR_Data[15:16-OPW];
  assign rsel   = IR_Data[9:8];
  assign s_bit  = IR_Data[9];
  assign dst    = IR_Data[7:6];
  assign sr1    = IR_Data[4:3];
  assign sr2    = IR_Data[1:0];
  assign z_flag = Flags[3];
  // Register fields only use their low two bits; C/N/O never steer control flow.
  assign unused_bits = ^{Flags[2:0], IR_Data[5], IR_Data[2]};

  function automatic logic [3:0] rf_load_sel(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_INIT;
      t_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    illegal_d   = illegal_q;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 3'b000;
    RF_RegSel   = 4'b1111;
    RF_ScrSel   = 4'b1111;
    ALU_FunSel  = 5'b00000;
    ALU_WF      = 1'b0;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 2'b00;
    MuxDSel     = 1'b0;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 3'b111;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    DR_E        = 1'b0;
    DR_FunSel   = 2'b00;

    // Outputs stay idle for the whole time Reset is held, even though state is INIT.
    if (!Reset) begin
      case (state_q)
        ST_INIT: begin
          ARF_RegSel = 3'b000;
          ARF_FunSel = 2'b11;
          RF_RegSel  = 4'b0000;
          RF_FunSel  = 3'b011;
          state_d    = ST_RUN;
          t_d        = '0;
        end

        ST_RUN: begin
          case (t_q)
            TW'(0), TW'(1): begin
              ARF_OutDSel = 2'b00;
              Mem_CS      = 1'b0;
              IR_Write    = 1'b1;
              IR_LH       = (t_q == TW'(1));
              ARF_RegSel  = 3'b011;
              ARF_FunSel  = 2'b01;
              t_d         = t_q + TW'(1);
            end

            TW'(2): begin
              t_d = '0;
              case (op)
                OP_BRA, OP_BNE, OP_BEQ: begin
                  if ((op == OP_BRA) || ((op == OP_BNE) && !z_flag) ||
                      ((op == OP_BEQ) && z_flag)) begin
                    MuxBSel    = 2'b11;
                    ARF_RegSel = 3'b011;
                    ARF_FunSel = 2'b10;
                  end
                end
                OP_MOVL: begin
                  MuxASel   = 2'b11;
                  RF_RegSel = rf_load_sel(rsel);
                  RF_FunSel = 3'b010;
                end
                OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
                  RF_OutASel = {1'b0, sr1};
                  RF_OutBSel = {1'b0, sr2};
                  MuxDSel    = 1'b0;
                  MuxASel    = 2'b00;
                  RF_RegSel  = rf_load_sel(dst);
                  RF_FunSel  = 3'b010;
                  ALU_WF     = s_bit;
                  case (op)
                    OP_ADD:  ALU_FunSel = 5'b10100;
                    OP_SUB:  ALU_FunSel = 5'b10110;
                    OP_AND:  ALU_FunSel = 5'b10111;
                    OP_ORR:  ALU_FunSel = 5'b11000;
                    default: ALU_FunSel = 5'b11001;
                  endcase
                end
                OP_LDB: begin
                  ARF_OutDSel = ARF_SEL_AR;
                  Mem_CS      = 1'b0;
                  DR_E        = 1'b1;
                  DR_FunSel   = 2'b01;
                  t_d         = TW'(3);
                end
                OP_STB: begin
                  RF_OutASel  = {1'b0, rsel};
                  MuxDSel     = 1'b0;
                  ALU_FunSel  = 5'b10000;
                  MuxCSel     = 2'b00;
                  ARF_OutDSel = ARF_SEL_AR;
                  Mem_CS      = 1'b0;
                  Mem_WR      = 1'b1;
                end
                OP_HLT: begin
                  state_d = ST_HALT;
                  t_d     = t_q;
                end
                default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                  state_d   = ST_HALT;
                  t_d       = t_q;
                  illegal_d = 1'b1;
`else
                  t_d       = '0;
`endif
                end
              endcase
            end

            TW'(3): begin
              if (op == OP_LDB) begin
                MuxASel   = 2'b10;
                RF_RegSel = rf_load_sel(rsel);
                RF_FunSel = 3'b010;
              end
              t_d = '0;
            end

            default: t_d = '0;
          endcase
        end

        ST_HALT: begin
          state_d = ST_HALT;
        end

        default: state_d = ST_INIT;
      endcase
    end
  end

  assign T      = t_q;
  assign Halted = (state_q == ST_HALT);
`ifdef CU_ILLEGAL_TRAP_EN
  assign Illegal = illegal_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed scoreboard bench for control_unit (IR_Data driven as if latched by IR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  typedef struct packed {
    logic [2:0] oa;
    logic [2:0] ob;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] mxa;
    logic [1:0] mxb;
    logic [1:0] mxc;
    logic       mxd;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [1:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_wr;
    logic       mem_wr;
    logic       mem_cs;
    logic       dr_e;
    logic [1:0] dr_fun;
  } ctl_t;

  logic        Clock, Reset;
  logic [15:0] IR_Data;
  logic [3:0]  Flags;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_RegSel, T;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF, MuxDSel, IR_LH, IR_Write, Mem_WR, Mem_CS, DR_E, Halted;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, DR_FunSel;
`ifdef CU_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  control_unit #(.TW(3), .OPW(6)) dut (
    .Clock(Clock), .Reset(Reset), .IR_Data(IR_Data), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .MuxDSel(MuxDSel), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .DR_E(DR_E),
    .DR_FunSel(DR_FunSel), .T(T),
`ifdef CU_ILLEGAL_TRAP_EN
    .Illegal(Illegal),
`endif
    .Halted(Halted)
  );

  ctl_t act;
  assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel,
                ALU_WF, MuxASel, MuxBSel, MuxCSel, MuxDSel, ARF_OutCSel, ARF_OutDSel,
                ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, DR_E, DR_FunSel};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  ctl_t       exp_ctl_q[$];
  logic [2:0] exp_t_q[$];
  logic       exp_h_q[$];
  string      tag_q[$];

  function automatic ctl_t idle_v();
    ctl_t c;
    c         = '0;
    c.rf_reg  = 4'b1111;
    c.rf_scr  = 4'b1111;
    c.arf_reg = 3'b111;
    c.mem_cs  = 1'b1;
    return c;
  endfunction

  function automatic ctl_t init_v();
    ctl_t c;
    c         = idle_v();
    c.arf_reg = 3'b000;
    c.arf_fun = 2'b11;
    c.rf_reg  = 4'b0000;
    c.rf_fun  = 3'b011;
    return c;
  endfunction

  function automatic ctl_t fetch_v(input logic lh);
    ctl_t c;
    c         = idle_v();
    c.arf_d   = 2'b00;
    c.mem_cs  = 1'b0;
    c.ir_wr   = 1'b1;
    c.ir_lh   = lh;
    c.arf_reg = 3'b011;
    c.arf_fun = 2'b01;
    return c;
  endfunction

  function automatic ctl_t branch_v();
    ctl_t c;
    c         = idle_v();
    c.mxb     = 2'b11;
    c.arf_reg = 3'b011;
    c.arf_fun = 2'b10;
    return c;
  endfunction

  // Queue the expectation for this cycle, then retire it mid-cycle once outputs settle.
  task automatic cyc(input string tag, input ctl_t e, input logic [2:0] et, input logic eh);
    ctl_t       ec;
    logic [2:0] etq;
    logic       ehq;
    string      tg;
    exp_ctl_q.push_back(e);
    exp_t_q.push_back(et);
    exp_h_q.push_back(eh);
    tag_q.push_back(tag);
    @(negedge Clock);
    ec  = exp_ctl_q.pop_front();
    etq = exp_t_q.pop_front();
    ehq = exp_h_q.pop_front();
    tg  = tag_q.pop_front();
    checks++;
    assert (act === ec) else begin
      failures++;
      $error("FAIL %s ctl observed=%h expected=%h", tg, act, ec);
    end
    checks++;
    assert (T === etq) else begin
      failures++;
      $error("FAIL %s T observed=%0d expected=%0d", tg, T, etq);
    end
    checks++;
    assert (Halted === ehq) else begin
      failures++;
      $error("FAIL %s Halted observed=%b expected=%b", tg, Halted, ehq);
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ins);
    cyc("fetch_t0", fetch_v(1'b0), 3'd0, 1'b0);
    cyc("fetch_t1", fetch_v(1'b1), 3'd1, 1'b0);
    IR_Data = ins;
  endtask

  logic [5:0] alu_ops  [4] = '{6'h05, 6'h06, 6'h07, 6'h08};
  logic [4:0] alu_funs [4] = '{5'b10110, 5'b10111, 5'b11000, 5'b11001};

  initial begin
    ctl_t e;
    Reset   = 1'b1;
    Flags   = 4'b0000;
    IR_Data = 16'h0000;
    #1;
    cyc("reset", idle_v(), 3'd0, 1'b0);
    Reset = 1'b0;
    cyc("init", init_v(), 3'd0, 1'b0);

    // MOVL R2,5
    fetch(16'h0D05);
    e = idle_v(); e.mxa = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b1011;
    cyc("movl", e, 3'd2, 1'b0);

    // ADD S=1 R1 = R2 + R3
    fetch(16'h120A);
    e = idle_v(); e.oa = 3'b001; e.ob = 3'b010; e.alu_fun = 5'b10100; e.alu_wf = 1'b1;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0111;
    cyc("add", e, 3'd2, 1'b0);

    // SUB/AND/ORR/XOR S=0 R4 = R3 op R4
    for (int i = 0; i < 4; i++) begin
      fetch({alu_ops[i], 1'b0, 3'b011, 3'b010, 3'b011});
      e = idle_v(); e.oa = 3'b010; e.ob = 3'b011; e.alu_fun = alu_funs[i];
      e.rf_fun = 3'b010; e.rf_reg = 4'b1110;
      cyc("alu", e, 3'd2, 1'b0);
    end

    Flags = 4'b0000;
    fetch(16'h0820);
    cyc("beq_z0", idle_v(), 3'd2, 1'b0);
    Flags = 4'b1000;
    fetch(16'h0820);
    cyc("beq_z1", branch_v(), 3'd2, 1'b0);
    fetch(16'h0420);
    cyc("bne_z1", idle_v(), 3'd2, 1'b0);
    Flags = 4'b0111;
    fetch(16'h0420);
    cyc("bne_z0", branch_v(), 3'd2, 1'b0);
    fetch(16'h0010);
    cyc("bra", branch_v(), 3'd2, 1'b0);

    // LDB R4 (two execute steps)
    fetch(16'h2700);
    e = idle_v(); e.arf_d = 2'b01; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun = 2'b01;
    cyc("ldb_t2", e, 3'd2, 1'b0);
    e = idle_v(); e.mxa = 2'b10; e.rf_fun = 3'b010; e.rf_reg = 4'b1110;
    cyc("ldb_t3", e, 3'd3, 1'b0);

    // STB R2
    fetch(16'h2900);
    e = idle_v(); e.oa = 3'b001; e.alu_fun = 5'b10000; e.arf_d = 2'b01;
    e.mem_cs = 1'b0; e.mem_wr = 1'b1;
    cyc("stb", e, 3'd2, 1'b0);

    // Reset asserted during T1 aborts the instruction
    cyc("abort_t0", fetch_v(1'b0), 3'd0, 1'b0);
    Reset = 1'b1;
    cyc("abort_rst", idle_v(), 3'd0, 1'b0);
    Reset = 1'b0;
    cyc("abort_init", init_v(), 3'd0, 1'b0);
    fetch(16'h0D05);
    e = idle_v(); e.mxa = 2'b11; e.rf_fun = 3'b010; e.rf_reg = 4'b1011;
    cyc("post_abort", e, 3'd2, 1'b0);

    // HLT freezes T and idles outputs
    fetch(16'hFC00);
    cyc("hlt_t2", idle_v(), 3'd2, 1'b0);
    for (int i = 0; i < 12; i++) cyc("halted", idle_v(), 3'd2, 1'b1);
    Reset = 1'b1;
    cyc("hlt_rst", idle_v(), 3'd0, 1'b0);
    Reset = 1'b0;
    cyc("hlt_init", init_v(), 3'd0, 1'b0);

    // Undefined opcode 0x20
    fetch(16'h8000);
    cyc("undef_t2", idle_v(), 3'd2, 1'b0);
`ifdef CU_ILLEGAL_TRAP_EN
    cyc("undef_halt", idle_v(), 3'd2, 1'b1);
    checks++;
    assert (Illegal === 1'b1) else begin
      failures++;
      $error("FAIL undef_illegal observed=%b expected=1", Illegal);
    end
`else
    cyc("undef_resume", fetch_v(1'b0), 3'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
